// File: rtl/temp_alarm_pkg.sv
// rtl/temp_alarm_pkg.sv - shared widths and state encodings for the temperature alarm block
package temp_alarm_pkg;
  localparam int CNT_W = 4;
  localparam int EVT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMING  = 2'd1,
    ST_ALARM   = 2'd2,
    ST_COOLING = 2'd3
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;
endmodule

// File: rtl/temperature_alarm_ctrl.sv
// rtl/temperature_alarm_ctrl.sv - debounces comparator alerts into a latched, acknowledged alarm
module temperature_alarm_ctrl
  import temp_alarm_pkg::*;
#(
  parameter int CONFIRM_CNT = 4,
  parameter int RELEASE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic             alert,
  input  logic             ack,
  output logic             alarm,
  output logic             alarm_rise,
  output logic [1:0]       state,
  output logic [EVT_W-1:0] event_count
);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             alarm_q;
  logic             rise_q;
  logic             new_event;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Only a fresh confirmation counts as an event; re-entry from COOLING does not.
  always_comb begin
    new_event = 1'b0;
    if (sample_valid && alert) begin
      case (state_q)
        ST_IDLE:   new_event = (CONFIRM_CNT == 1);
        ST_ARMING: new_event = (cnt_inc == CNT_W'(CONFIRM_CNT));
        default:   new_event = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= new_event;
      unique case (state_q)
        ST_IDLE: begin
          if (new_event) begin
            state_q <= ST_ALARM;
            cnt_q   <= '0;
            alarm_q <= 1'b1;
          end else if (sample_valid && alert) begin
            state_q <= ST_ARMING;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_ARMING: begin
          if (sample_valid) begin
            if (new_event) begin
              state_q <= ST_ALARM;
              cnt_q   <= '0;
              alarm_q <= 1'b1;
            end else if (alert) begin
              cnt_q <= cnt_inc;
            end else begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end
          end
        end
        ST_ALARM: begin
          if (sample_valid) begin
            if (alert) begin
              cnt_q <= '0;
            end else if (cnt_inc == CNT_W'(RELEASE_CNT)) begin
              state_q <= ST_COOLING;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_COOLING: begin
          if (sample_valid && alert) begin
            state_q <= ST_ALARM;
            cnt_q   <= '0;
          end else if (ack) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
          end
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(EVT_W)) u_event_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (new_event),
    .clr   (1'b0),
    .count (event_count)
  );

  assign alarm      = alarm_q;
  assign alarm_rise = rise_q;
  assign state      = state_q;
endmodule

// File: doc/temperature_alarm_ctrl.md
# temperature_alarm_ctrl

Debounce and latch stage directly downstream of the temperature/threshold comparator. It consumes the raw per-sample `alert` bit and confirms it over consecutive samples before asserting a latched `alarm`. Once the condition has cleared, the alarm is released only after operator acknowledge. It also keeps a saturating count of confirmed alarm events for status readout.

## Interface
- `CONFIRM_CNT`, 4: consecutive alerting samples required to enter alarm; legal range 1..15.
- `RELEASE_CNT`, 4: consecutive non-alerting samples required before the alarm can be acknowledged; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe; `alert` is sampled only when high.
- `alert`  in  1  raw comparator output.
- `ack`  in  1  operator acknowledge, level or pulse.
- `alarm`  out  1  latched alarm, registered.
- `alarm_rise`  out  1  one-cycle pulse on a new alarm event, registered.
- `state`  out  2  current FSM state, for debug/status.
- `event_count`  out  8  confirmed alarm events, saturating at 255.

## Operation
- One 4-bit sample counter `cnt` is shared by the ARMING and ALARM states.
- Cycles with `sample_valid`=0 change nothing (no counting), except `ack` handling in COOLING.
- IDLE (0):
  - `alarm`=0, `cnt`=0.
  - Valid sample with `alert`=1: go to ALARM if `CONFIRM_CNT`==1, otherwise go to ARMING with `cnt`=1.
- ARMING (1):
  - Valid `alert`=1: increment `cnt`. When the incremented value equals `CONFIRM_CNT`, go to ALARM and clear `cnt`.
  - Valid `alert`=0: return to IDLE with `cnt`=0; no partial credit is kept.
- ALARM (2):
  - `alarm`=1; `cnt` counts consecutive clear samples.
  - Valid `alert`=1: `cnt`=0.
  - Valid `alert`=0: increment `cnt`. When it reaches `RELEASE_CNT`, go to COOLING.
  - `ack` is ignored in this state; the alarm cannot be acknowledged while the condition persists.
- COOLING (3):
  - `alarm`=1.
  - `ack`=1: go to IDLE, `alarm`=0.
  - Valid `alert`=1 in the same cycle as `ack`: the alert wins. Go to ALARM with `cnt`=0; no `alarm_rise`, no count increment.
  - Re-entry to ALARM from COOLING is not a new event.
- `alarm_rise` and the `event_count` increment happen only on the IDLE->ALARM or ARMING->ALARM transition.
- `event_count` holds at 255 and does not wrap.

## Timing
- All outputs are registered. Reset value of every output and of `cnt` is 0; `state` resets to IDLE.
- Reset mid-operation aborts immediately, with no pulse.
- Alarm latency: `alarm` is high in the cycle after the clock edge that samples the `CONFIRM_CNT`-th consecutive valid alert. `alarm_rise` and the `event_count` update appear in that same cycle.
- Release latency: at the earliest, `alarm` drops one cycle after the `ack` edge. That edge must come after the `RELEASE_CNT`-th consecutive clear sample has been registered.
- Back-to-back valid samples, one per cycle, are legal. Spacing between samples is arbitrary; only valid samples count toward "consecutive".

## Structure
- Shared package/header `temp_alarm_pkg`:
  - state encodings `ST_IDLE`=0, `ST_ARMING`=1, `ST_ALARM`=2, `ST_COOLING`=3;
  - `EVT_W`=8;
  - `CNT_W`=4.
- One sub-module, `sat_counter` (parameter width; ports `inc` and `clr`), implements `event_count`.
- The FSM and `cnt` live in the top module.

## Test plan
- Defaults. Valid samples alert=1,1,1,1 -> `alarm` high after the 4th; `alarm_rise` high exactly 1 cycle; `event_count`=1.
- Valid alert=1,1,1,0,1,1,1 -> no alarm (counter restarts at 0); a further 1 makes four consecutive -> alarm.
- In ALARM: `ack` held high while alert=1, then 3 clear samples -> `alarm` stays 1. A 4th clear sample -> state=3. `ack` -> `alarm`=0 next cycle.
- In COOLING: assert `ack` and valid `alert`=1 together -> state=2, `alarm` stays 1, `alarm_rise`=0, `event_count` unchanged.
- Drive 256 full alarm cycles -> `event_count`=255 and holds; `CONFIRM_CNT`=1 build: a single valid alert -> alarm on the next cycle.
- Pull `rst_n` low asynchronously mid-ARMING and mid-ALARM -> all outputs 0 before the next clock edge; the first sequence after release starts from IDLE.
